// File: rtl/binary_to_excess3.sv
// ---------------------------------------------------------------------------
// binary_to_excess3
//
// Converts an unsigned N-bit binary word into its excess-3 code (din + 3).
// The result is N+1 bits wide, so every input converts without loss; the
// largest input 2^N-1 becomes 2^N+2.
//
// The block is a single-entry output register with valid/ready handshakes
// on both sides. A word accepted on a rising edge appears on dout on that
// same edge (latency of one cycle). Back-to-back words stream at one per
// cycle while downstream keeps out_ready high.
//
// Parameters:
//    N          input word width in bits (N >= 2)
//
// Ports:
//    clk        clock, rising-edge active
//    rst_n      asynchronous active-low reset; clears out_valid and dout
//    in_valid   din carries a valid word this cycle
//    in_ready   block can accept a word this cycle
//    din        unsigned binary value to convert (N bits)
//    out_valid  dout holds a valid converted word
//    out_ready  downstream accepts dout this cycle
//    dout       excess-3 code of the accepted din (N+1 bits, registered)
// ---------------------------------------------------------------------------
module binary_to_excess3 #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] din,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N:0]   dout
);

   // The excess-3 bias, held at the output width so the addition below is
   // performed entirely at N+1 bits.
   localparam logic [N:0] BIAS = (N+1)'(3);

   logic       in_xfer;
   logic [N:0] sum;

   // The output register can take a new word when it is empty or when its
   // current word leaves on this same edge. This is the only combinational
   // path from an input (out_ready) to an output (in_ready); din never
   // reaches dout without passing through the register.
   assign in_ready = !out_valid || out_ready;

   // An input transfer happens whenever upstream offers a word and we can
   // take it. During reset the registers are held clear regardless.
   assign in_xfer  = in_valid && in_ready;

   // Zero-extend before adding so the carry out of the top input bit lands
   // in dout[N] instead of being lost.
   assign sum      = {1'b0, din} + BIAS;

   // Valid flag for the output register. A new input sets it; an output
   // transfer with no replacement word clears it; otherwise it holds, which
   // keeps a stalled word visible until downstream takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else if (in_xfer) begin
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Data half of the output register. It only ever loads on an input
   // transfer, so dout never changes without a newly accepted word even
   // when out_valid is low. Reset clears it so a discarded word cannot
   // linger on the bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (in_xfer) begin
         dout <= sum;
      end
   end

endmodule

// File: tb/tb_binary_to_excess3.sv
// ---------------------------------------------------------------------------
// tb_binary_to_excess3
//
// Self-checking bench for binary_to_excess3. Two instances run side by side:
// one at N=4 (directed, table-driven and random traffic) and one at N=8
// (boundary and random traffic). Each instance has a scoreboard queue that
// receives din+3 on every input transfer and is checked against dout on
// every output transfer.
// ---------------------------------------------------------------------------
module tb_binary_to_excess3;

   typedef struct {
      logic [3:0] din;
      logic [4:0] expDout;
   } vec4_t;

   logic       clk;
   logic       rst_n;

   logic       inValid4;
   logic       inReady4;
   logic [3:0] din4;
   logic       outValid4;
   logic       outReady4;
   logic [4:0] dout4;

   logic       inValid8;
   logic       inReady8;
   logic [7:0] din8;
   logic       outValid8;
   logic       outReady8;
   logic [8:0] dout8;

   int checks = 0;
   int fails  = 0;
   int accepted4 = 0;
   int accepted8 = 0;

   logic [4:0] sb4[$];
   logic [8:0] sb8[$];

   binary_to_excess3 #(.N(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid4),
      .in_ready  (inReady4),
      .din       (din4),
      .out_valid (outValid4),
      .out_ready (outReady4),
      .dout      (dout4)
   );

   binary_to_excess3 #(.N(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid8),
      .in_ready  (inReady8),
      .din       (din8),
      .out_valid (outValid8),
      .out_ready (outReady8),
      .dout      (dout8)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports a mismatch on a single line.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge; inputs are changed here
   // and outputs are inspected here, well clear of the active edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Drive the N=4 instance's inputs and let one edge go by.
   task automatic applyStimulus(input logic v, input logic [3:0] d, input logic r);
      inValid4  = v;
      din4      = d;
      outReady4 = r;
      tick();
   endtask

   // Scoreboard for N=4. Sampled at the falling edge, when the inputs for
   // the coming rising edge are settled and the outputs reflect the last one.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("inReady4", {31'b0, inReady4}, {31'b0, (!outValid4 || outReady4)});
         if (outValid4 && outReady4) begin
            if (sb4.size() == 0) begin
               checkOutput("sb4Unexpected", 32'd1, 32'd0);
            end else begin
               checkOutput("sb4Dout", {27'b0, dout4}, {27'b0, sb4.pop_front()});
            end
         end
         if (inValid4 && inReady4) begin
            sb4.push_back({1'b0, din4} + 5'd3);
            accepted4++;
         end
      end
   end

   // Scoreboard for N=8, same timing as above.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("inReady8", {31'b0, inReady8}, {31'b0, (!outValid8 || outReady8)});
         if (outValid8 && outReady8) begin
            if (sb8.size() == 0) begin
               checkOutput("sb8Unexpected", 32'd1, 32'd0);
            end else begin
               checkOutput("sb8Dout", {23'b0, dout8}, {23'b0, sb8.pop_front()});
            end
         end
         if (inValid8 && inReady8) begin
            sb8.push_back({1'b0, din8} + 9'd3);
            accepted8++;
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec4_t vecs[16];
      int    cycles;

      for (int i = 0; i < 16; i++) begin
         vecs[i].din     = 4'(i);
         vecs[i].expDout = 5'(i + 3);
      end

      inValid4 = 1'b0; din4 = '0; outReady4 = 1'b1;
      inValid8 = 1'b0; din8 = '0; outReady8 = 1'b1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Reset state, and in_ready high while reset is held.
      tick();
      tick();
      checkOutput("rstOutValid4", {31'b0, outValid4}, 32'd0);
      checkOutput("rstDout4", {27'b0, dout4}, 32'd0);
      checkOutput("rstInReady4", {31'b0, inReady4}, 32'd1);
      checkOutput("rstOutValid8", {31'b0, outValid8}, 32'd0);
      rst_n = 1'b1;

      // First word right after reset release: 0 -> 3.
      applyStimulus(1'b1, 4'd0, 1'b1);
      checkOutput("firstValid", {31'b0, outValid4}, 32'd1);
      checkOutput("firstDout", {27'b0, dout4}, 32'd3);

      // Streaming 0..15 at one word per cycle.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, vecs[i].din, 1'b1);
         checkOutput("streamDout", {27'b0, dout4}, {27'b0, vecs[i].expDout});
         checkOutput("streamValid", {31'b0, outValid4}, 32'd1);
      end
      checkOutput("streamLast", {27'b0, dout4}, 32'd18);
      applyStimulus(1'b0, 4'd0, 1'b1);
      checkOutput("drainValid", {31'b0, outValid4}, 32'd0);

      // Stall: 7 accepted, then out_ready low for three cycles.
      applyStimulus(1'b1, 4'd7, 1'b0);
      checkOutput("stallLoad", {27'b0, dout4}, 32'd10);
      for (int i = 0; i < 3; i++) begin
         inValid4 = 1'b1;
         din4     = 4'(i + 1);
         #1;
         checkOutput("stallInReady", {31'b0, inReady4}, 32'd0);
         tick();
         checkOutput("stallDout", {27'b0, dout4}, 32'd10);
         checkOutput("stallValid", {31'b0, outValid4}, 32'd1);
      end

      // Release the stall together with a new word: 12 -> 15.
      inValid4  = 1'b1;
      din4      = 4'd12;
      outReady4 = 1'b1;
      #1;
      checkOutput("releaseInReady", {31'b0, inReady4}, 32'd1);
      tick();
      checkOutput("releaseDout", {27'b0, dout4}, 32'd15);
      checkOutput("releaseValid", {31'b0, outValid4}, 32'd1);
      applyStimulus(1'b0, 4'd0, 1'b1);

      // Asynchronous reset while a word is held.
      applyStimulus(1'b1, 4'd5, 1'b0);
      checkOutput("heldDout", {27'b0, dout4}, 32'd8);
      inValid4 = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("asyncValid", {31'b0, outValid4}, 32'd0);
      checkOutput("asyncDout", {27'b0, dout4}, 32'd0);
      sb4.delete();
      sb8.delete();
      tick();
      rst_n = 1'b1;

      // First edge after release already accepts: 9 -> 12.
      applyStimulus(1'b1, 4'd9, 1'b1);
      checkOutput("postRstDout", {27'b0, dout4}, 32'd12);
      checkOutput("postRstValid", {31'b0, outValid4}, 32'd1);
      applyStimulus(1'b0, 4'd0, 1'b1);

      // N=8 boundary: 255 -> 258, and the smallest input.
      inValid8 = 1'b1; din8 = 8'd255; outReady8 = 1'b1;
      tick();
      checkOutput("max8Dout", {23'b0, dout8}, 32'd258);
      din8 = 8'd0;
      tick();
      checkOutput("min8Dout", {23'b0, dout8}, 32'd3);
      inValid8 = 1'b0;
      tick();

      // Random traffic on both instances until each has taken 20 more words.
      accepted4 = 0;
      accepted8 = 0;
      cycles    = 0;
      while ((accepted4 < 20 || accepted8 < 20) && cycles < 1000) begin
         inValid4  = (accepted4 < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
         din4      = 4'($urandom_range(0, 15));
         outReady4 = 1'($urandom_range(0, 1));
         inValid8  = (accepted8 < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
         din8      = 8'($urandom_range(0, 255));
         outReady8 = 1'($urandom_range(0, 1));
         tick();
         cycles++;
      end
      checkOutput("rand4Accepted", 32'(accepted4), 32'd20);
      checkOutput("rand8Accepted", 32'(accepted8), 32'd20);

      // Drain whatever is still held and confirm nothing was lost.
      inValid4 = 1'b0; outReady4 = 1'b1;
      inValid8 = 1'b0; outReady8 = 1'b1;
      cycles = 0;
      while ((sb4.size() != 0 || sb8.size() != 0) && cycles < 20) begin
         tick();
         cycles++;
      end
      tick();
      checkOutput("sb4Drained", 32'(sb4.size()), 32'd0);
      checkOutput("sb8Drained", 32'(sb8.size()), 32'd0);
      checkOutput("idleValid4", {31'b0, outValid4}, 32'd0);
      checkOutput("idleValid8", {31'b0, outValid8}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
